// File: rtl/vit_ctrl.sv
// vit_ctrl: frame sequencer and path-metric controller for the pipelined Viterbi decoder.
// Defining VIT_CTRL_STAT_EN adds norm_cnt, a saturating count of pm_norm pulses.
module vit_ctrl #(
   parameter int FRAME_LEN = 64,
   parameter int PIPE_LAT  = 8,
   parameter int NORM_THR  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        sym_valid,
   output logic        sym_ready,
   input  logic [6:0]  PM_1,
   input  logic [6:0]  PM_2,
   input  logic [6:0]  PM_3,
   input  logic [6:0]  PM_4,
   output logic        pm_init,
   output logic        acs_en,
   output logic        pm_norm,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic        dec_last,
   output logic        frame_done,
`ifdef VIT_CTRL_STAT_EN
   output logic [15:0] norm_cnt,
`endif
   output logic        busy
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] INIT  = 3'd1;
   localparam logic [2:0] RUN   = 3'd2;
   localparam logic [2:0] FLUSH = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [6:0] THR      = 7'(NORM_THR);
   localparam logic [7:0] LEN      = 8'(FRAME_LEN);
   localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

   logic [2:0]          state, state_nxt;
   logic [PIPE_LAT-1:0] tok;
   logic [7:0]          in_cnt, out_cnt;
   logic                stall, active, accept, xfer, pm_all_ge;

   assign dec_valid = tok[PIPE_LAT-1];
   assign dec_last  = dec_valid && (out_cnt == LAST_IDX);
   assign stall     = dec_valid && !dec_ready;
   assign active    = (state == RUN) || (state == FLUSH);
   assign acs_en    = active && !stall;
   assign sym_ready = (state == RUN) && !stall && (in_cnt < LEN);
   assign accept    = sym_valid && sym_ready;
   assign xfer      = dec_valid && dec_ready;
   assign pm_all_ge = (PM_1 >= THR) && (PM_2 >= THR) && (PM_3 >= THR) && (PM_4 >= THR);

   // The last byte can leave while still in RUN when PIPE_LAT is short, so both
   // RUN and FLUSH finish the frame on the dec_last transfer.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_start) state_nxt = INIT;
         INIT:    state_nxt = RUN;
         RUN: begin
            if (xfer && dec_last)   state_nxt = DONE;
            else if (in_cnt == LEN) state_nxt = FLUSH;
         end
         FLUSH:   if (xfer && dec_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         tok        <= '0;
         in_cnt     <= '0;
         out_cnt    <= '0;
         pm_init    <= 1'b0;
         pm_norm    <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         pm_init    <= (state_nxt == INIT);
         busy       <= (state_nxt != IDLE);
         frame_done <= (state_nxt == DONE);
         // Never back-to-back, so the datapath PMs settle between subtractions.
         pm_norm    <= acs_en && pm_all_ge && !pm_norm &&
                       ((state_nxt == RUN) || (state_nxt == FLUSH));
         if (state == INIT) begin
            tok     <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
         end else begin
            if (acs_en) begin
               for (int i = PIPE_LAT - 1; i > 0; i--) tok[i] <= tok[i-1];
               tok[0] <= accept;
            end
            if (accept) in_cnt  <= in_cnt + 8'd1;
            if (xfer)   out_cnt <= out_cnt + 8'd1;
         end
      end
   end

`ifdef VIT_CTRL_STAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         norm_cnt <= '0;
      else if (pm_init)
         norm_cnt <= '0;
      else if (pm_norm && (norm_cnt != 16'hFFFF))
         norm_cnt <= norm_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_vit_ctrl.sv
// Directed self-checking bench for vit_ctrl with FRAME_LEN=4, PIPE_LAT=3, NORM_THR=64.
module tb_vit_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_start, sym_valid, sym_ready;
   logic [6:0] PM_1, PM_2, PM_3, PM_4;
   logic       pm_init, acs_en, pm_norm, dec_valid, dec_ready, dec_last, frame_done, busy;
`ifdef VIT_CTRL_STAT_EN
   logic [15:0] norm_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // Per-cycle output records of the last frame, bit c = cycle c after frame_start.
   logic [31:0] r_sr, r_pi, r_ae, r_pn, r_dv, r_dl, r_fd, r_bz;
   int          nbytes;
   logic [7:0]  outs;

   vit_ctrl #(.FRAME_LEN(4), .PIPE_LAT(3), .NORM_THR(64)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .sym_valid(sym_valid), .sym_ready(sym_ready),
      .PM_1(PM_1), .PM_2(PM_2), .PM_3(PM_3), .PM_4(PM_4),
      .pm_init(pm_init), .acs_en(acs_en), .pm_norm(pm_norm),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_last(dec_last),
      .frame_done(frame_done),
`ifdef VIT_CTRL_STAT_EN
      .norm_cnt(norm_cnt),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Called just after a rising edge with the DUT idle; cycle 0 carries frame_start.
   task automatic drive_frame(input logic [31:0] sv, input logic [31:0] dr, input int ncyc);
      r_sr = '0; r_pi = '0; r_ae = '0; r_pn = '0;
      r_dv = '0; r_dl = '0; r_fd = '0; r_bz = '0;
      nbytes = 0;
      for (int c = 0; c < ncyc; c++) begin
         frame_start = (c == 0);
         sym_valid   = sv[c];
         dec_ready   = dr[c];
         @(negedge clk);
         r_sr[c] = sym_ready;  r_pi[c] = pm_init;  r_ae[c] = acs_en;   r_pn[c] = pm_norm;
         r_dv[c] = dec_valid;  r_dl[c] = dec_last; r_fd[c] = frame_done; r_bz[c] = busy;
         if (dec_valid && dec_ready) nbytes++;
         @(posedge clk); #1;
      end
      frame_start = 1'b0;
      sym_valid   = 1'b0;
      dec_ready   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         frame_start = c[0];
         sym_valid   = ~c[0];
         dec_ready   = c[1];
         PM_1 = 7'd100; PM_2 = 7'd100; PM_3 = 7'd100; PM_4 = 7'd100;
         @(negedge clk);
         outs = {sym_ready, pm_init, acs_en, pm_norm, dec_valid, dec_last, frame_done, busy};
         checks++;
         if (outs !== 8'h00) begin
            errors++;
            $display("FAIL reset_outs cycle %0d: got %b want 00000000", c, outs);
         end
      end
      frame_start = 1'b0; sym_valid = 1'b0; dec_ready = 1'b0;
      PM_1 = 7'd0; PM_2 = 7'd0; PM_3 = 7'd0; PM_4 = 7'd0;
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         outs = {sym_ready, pm_init, acs_en, pm_norm, dec_valid, dec_last, frame_done, busy};
         checks++;
         if (outs !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset cycle %0d: got %b want 00000000", c, outs);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_nominal();
      drive_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 14);
      checks++; if (r_pi !== 32'h002) begin errors++; $display("FAIL nom_pm_init got %h want 002", r_pi); end
      checks++; if (r_sr !== 32'h03C) begin errors++; $display("FAIL nom_sym_ready got %h want 03c", r_sr); end
      checks++; if (r_ae !== 32'h1FC) begin errors++; $display("FAIL nom_acs_en got %h want 1fc", r_ae); end
      checks++; if (r_dv !== 32'h1E0) begin errors++; $display("FAIL nom_dec_valid got %h want 1e0", r_dv); end
      checks++; if (r_dl !== 32'h100) begin errors++; $display("FAIL nom_dec_last got %h want 100", r_dl); end
      checks++; if (r_fd !== 32'h200) begin errors++; $display("FAIL nom_frame_done got %h want 200", r_fd); end
      checks++; if (r_bz !== 32'h3FE) begin errors++; $display("FAIL nom_busy got %h want 3fe", r_bz); end
      checks++; if (r_pn !== 32'h000) begin errors++; $display("FAIL nom_pm_norm got %h want 000", r_pn); end
      checks++; if (nbytes !== 4)     begin errors++; $display("FAIL nom_bytes got %0d want 4", nbytes); end
   endtask

   task automatic test_backpressure();
      drive_frame(32'hFFFF_FFFF, 32'hFFFF_FF9F, 16);
      checks++; if (r_sr !== 32'h09C) begin errors++; $display("FAIL bp_sym_ready got %h want 09c", r_sr); end
      checks++; if (r_ae !== 32'h79C) begin errors++; $display("FAIL bp_acs_en got %h want 79c", r_ae); end
      checks++; if (r_dv !== 32'h7E0) begin errors++; $display("FAIL bp_dec_valid got %h want 7e0", r_dv); end
      checks++; if (r_dl !== 32'h400) begin errors++; $display("FAIL bp_dec_last got %h want 400", r_dl); end
      checks++; if (r_fd !== 32'h800) begin errors++; $display("FAIL bp_frame_done got %h want 800", r_fd); end
      checks++; if (r_bz !== 32'hFFE) begin errors++; $display("FAIL bp_busy got %h want ffe", r_bz); end
      checks++; if (nbytes !== 4)     begin errors++; $display("FAIL bp_bytes got %0d want 4", nbytes); end
   endtask

   task automatic test_bubble();
      drive_frame(32'hFFFF_FFF7, 32'hFFFF_FFFF, 14);
      checks++; if (r_sr !== 32'h07C) begin errors++; $display("FAIL bub_sym_ready got %h want 07c", r_sr); end
      checks++; if (r_ae !== 32'h3FC) begin errors++; $display("FAIL bub_acs_en got %h want 3fc", r_ae); end
      checks++; if (r_dv !== 32'h3A0) begin errors++; $display("FAIL bub_dec_valid got %h want 3a0", r_dv); end
      checks++; if (r_dl !== 32'h200) begin errors++; $display("FAIL bub_dec_last got %h want 200", r_dl); end
      checks++; if (r_fd !== 32'h400) begin errors++; $display("FAIL bub_frame_done got %h want 400", r_fd); end
      checks++; if (r_bz !== 32'h7FE) begin errors++; $display("FAIL bub_busy got %h want 7fe", r_bz); end
      checks++; if (nbytes !== 4)     begin errors++; $display("FAIL bub_bytes got %0d want 4", nbytes); end
   endtask

   task automatic test_normalisation();
      PM_1 = 7'd70; PM_2 = 7'd65; PM_3 = 7'd80; PM_4 = 7'd64;
      drive_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 14);
      checks++; if (r_pn !== 32'h0A8) begin errors++; $display("FAIL norm_pulses got %h want 0a8", r_pn); end
      checks++;
      if ((r_pn & (r_pn >> 1)) !== 32'h0) begin
         errors++; $display("FAIL norm_consecutive got %h want 0", r_pn & (r_pn >> 1));
      end
`ifdef VIT_CTRL_STAT_EN
      checks++; if (norm_cnt !== 16'd3) begin errors++; $display("FAIL norm_cnt got %0d want 3", norm_cnt); end
`endif
      PM_4 = 7'd63;
      drive_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 14);
      checks++; if (r_pn !== 32'h000) begin errors++; $display("FAIL norm_below_thr got %h want 000", r_pn); end
`ifdef VIT_CTRL_STAT_EN
      checks++; if (norm_cnt !== 16'd0) begin errors++; $display("FAIL norm_cnt_cleared got %0d want 0", norm_cnt); end
`endif
      PM_1 = 7'd0; PM_2 = 7'd0; PM_3 = 7'd0; PM_4 = 7'd0;
   endtask

   task automatic test_mid_reset();
      sym_valid = 1'b1;
      dec_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         frame_start = (c == 0);
         @(posedge clk); #1;
      end
      frame_start = 1'b0;
      rst = 1'b0;
      #1;
      outs = {sym_ready, pm_init, acs_en, pm_norm, dec_valid, dec_last, frame_done, busy};
      checks++;
      if (outs !== 8'h00) begin errors++; $display("FAIL midrst_outs got %b want 00000000", outs); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if ({frame_done, busy} !== 2'b00) begin
            errors++; $display("FAIL midrst_hold cycle %0d got %b want 00", c, {frame_done, busy});
         end
      end
      rst = 1'b1;
      sym_valid = 1'b0;
      dec_ready = 1'b0;
      @(posedge clk); #1;
      drive_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 14);
      checks++; if (r_sr !== 32'h03C) begin errors++; $display("FAIL midrst_sym_ready got %h want 03c", r_sr); end
      checks++; if (r_dv !== 32'h1E0) begin errors++; $display("FAIL midrst_dec_valid got %h want 1e0", r_dv); end
      checks++; if (r_fd !== 32'h200) begin errors++; $display("FAIL midrst_frame_done got %h want 200", r_fd); end
      checks++; if (r_bz !== 32'h3FE) begin errors++; $display("FAIL midrst_busy got %h want 3fe", r_bz); end
   endtask

   initial begin
      rst = 1'b0; frame_start = 1'b0; sym_valid = 1'b0; dec_ready = 1'b0;
      PM_1 = 7'd0; PM_2 = 7'd0; PM_3 = 7'd0; PM_4 = 7'd0;
      test_reset();
      test_nominal();
      test_backpressure();
      test_bubble();
      test_normalisation();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vit_ctrl.md
# vit_ctrl

Frame sequencer and path-metric controller for the pipelined Viterbi decoder. It sits between the symbol source, the ACS/path-metric pipeline and the compare-select stage that emits decoded survivor bytes. Per frame it:
- initialises the path metrics,
- gates symbols into the pipeline,
- tracks in-flight symbols so the compare-select output carries a valid/ready handshake,
- issues path-metric normalisation pulses,
- flushes the pipeline at frame end.

## Interface
Parameters:
- FRAME_LEN, 64: symbols per frame; range 1..255.
- PIPE_LAT, 8: pipeline advances from symbol acceptance to a valid compare-select byte; range ≥ 1.
- NORM_THR, 64: normalisation threshold. The datapath subtracts exactly NORM_THR on pm_norm.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- frame_start in 1: starts a frame; honoured only in IDLE.
- sym_valid in 1: upstream symbol present.
- sym_ready out 1: symbol accepted when sym_valid && sym_ready.
- PM_1..PM_4 in 7 each: current path metrics, unsigned.
- pm_init out 1: one-cycle pulse; datapath clears path metrics.
- acs_en out 1: advance the ACS/path-metric pipeline one step.
- pm_norm out 1: one-cycle pulse; datapath subtracts NORM_THR from all PMs.
- dec_valid out 1: compare-select data_out holds a valid decoded byte.
- dec_ready in 1: downstream accepts the byte.
- dec_last out 1: qualifies the final byte of the frame; valid only with dec_valid.
- frame_done out 1: one-cycle pulse after the last byte transfers.
- busy out 1: state ≠ IDLE.

## Operation
States and transitions:
- IDLE → INIT on frame_start.
- INIT → RUN unconditionally. pm_init = 1 for this cycle; counters and token line are cleared.
- RUN → FLUSH once in_cnt = FRAME_LEN.
- FLUSH → DONE on the transfer with dec_last.
- DONE → IDLE unconditionally; frame_done = 1.

Token line (PIPE_LAT bits, tok[0..PIPE_LAT-1]):
- On each acs_en cycle: tok[0] ← (sym_valid && sym_ready), and the line shifts up.
- dec_valid = tok[PIPE_LAT-1].

Stall and handshake:
- stall = dec_valid && !dec_ready.
- acs_en = (RUN or FLUSH) && !stall. A RUN cycle without a symbol is a bubble: the pipeline advances and a 0 token enters.
- sym_ready = RUN && !stall && in_cnt < FRAME_LEN.
- acs_en and sym_ready are combinational from registered state and dec_ready. All other outputs are registered.

Counters:
- in_cnt counts accepted symbols.
- out_cnt counts transferred bytes.
- Both are 8-bit and never wrap within a frame.
- dec_last = dec_valid && out_cnt = FRAME_LEN-1.

Normalisation:
- Condition: acs_en cycle, all four PMs ≥ NORM_THR (unsigned 7-bit compare), and pm_norm currently 0.
- Response: pm_norm = 1 on the following cycle.
- Back-to-back pulses are never issued, so the PMs settle between pulses.
- pm_norm is forced 0 outside RUN/FLUSH.

Boundary rules:
- frame_start outside IDLE is ignored.
- sym_valid outside RUN is ignored.
- dec_ready without dec_valid has no effect.
- rst low at any time: immediately to IDLE, token line and counters cleared, all registered outputs 0. The frame in flight is discarded and no frame_done is produced.

## Timing
- Reset values: sym_ready, pm_init, acs_en, pm_norm, dec_valid, dec_last, frame_done and busy are all 0.
- Frame start: frame_start sampled in cycle c → pm_init in c+1 → first sym_ready in c+2.
- Pipeline latency: a symbol accepted in cycle t produces dec_valid in cycle t+PIPE_LAT, plus one cycle per stalled cycle in between.
- Stall behaviour: while stalled, dec_valid, dec_last and the token line hold, and the compare-select output must not change.
- Frame end: frame_done follows the dec_last transfer by one cycle. busy drops the cycle after that.

## Configuration
- VIT_CTRL_STAT_EN defined: adds output norm_cnt [15:0].
  - Counts pm_norm pulses and saturates at 16'hFFFF.
  - Cleared at reset and on pm_init.
  - Holds its value in IDLE.
- VIT_CTRL_STAT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
All scenarios use FRAME_LEN=4, PIPE_LAT=3, NORM_THR=64. Cycle numbers are relative to frame_start in cycle 0.
- Reset: rst low, all inputs toggling → every output 0 and busy 0. Release rst → IDLE, no pulses.
- Nominal: sym_valid=1, dec_ready=1 → pm_init in cycle 1; sym_ready in cycles 2–5; dec_valid in 5–8; dec_last in 8; frame_done in 9; busy 0 in 10.
- Backpressure: nominal with dec_ready=0 in cycles 5–6 → acs_en=0 and sym_ready=0 in 5–6; dec_valid held; four bytes still transferred; dec_last in 10; frame_done in 11.
- Bubble: sym_valid=0 in cycle 3 → dec_valid low in cycle 6; four bytes delivered; dec_last in 9; frame_done in 10.
- Normalisation:
  - PMs 70/65/80/64 held during RUN → pm_norm pulses every other cycle, never two consecutive.
  - With PM_4=63 → no pulse.
  - With VIT_CTRL_STAT_EN, norm_cnt equals the pulse count.
- Mid-frame reset: rst low in cycle 4 → all outputs 0 immediately, no frame_done. A new frame_start then reproduces the nominal sequence.
